// File: rtl/butterfly_recombine_if.sv
// Stream interface for the inverse butterfly: e/o words in, recovered samples out.
interface butterfly_recombine_if #(
   parameter int unsigned DW = 16
);
   logic          in_valid;
   logic          in_ready;
   logic [DW:0]   in_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_err;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_err
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, out_err
   );
endinterface

// File: rtl/butterfly_recombine.sv
// Inverse 8-point butterfly: buffers e0..e3,o0..o3 then serially emits x0..x7
// as (e +/- o) >>> 1 through a single ripple adder/subtractor.
module butterfly_recombine #(
   parameter int unsigned DW = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   butterfly_recombine_if.slave  bus
);

   typedef enum logic {StLoad, StDrain} state_e;

   state_e        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [DW:0]   rf_q [8];
   logic          wr_en;

   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic [DW-1:0] out_data_q, out_data_d;
   logic          out_last_q, out_last_d;
   logic          out_err_q, out_err_d;

   logic [2:0]    rd_idx;
   logic [1:0]    pair;
   logic          add_sub;
   logic [DW:0]   op_e, op_o;
   logic [DW+1:0] add_a, add_b, sum;
   logic          pair_err;
   logic          unused_sum_bits;

   // Index of the word that the output register loads next.
   always_comb begin
      rd_idx = (state_q == StLoad) ? 3'd0 : 3'(cnt_q + 3'd1);
   end

   // x0..x3 add pair k; x4..x7 subtract pair 7-k.
   always_comb begin
      add_sub  = rd_idx[2];
      pair     = rd_idx[2] ? ~rd_idx[1:0] : rd_idx[1:0];
      op_e     = rf_q[{1'b0, pair}];
      op_o     = rf_q[{1'b1, pair}];
      add_a    = {op_e[DW], op_e};
      add_b    = add_sub ? ~{op_o[DW], op_o} : {op_o[DW], op_o};
      pair_err = op_e[0] ^ op_o[0];
   end

   // Ripple-carry chain; subtraction enters as carry-in on the complemented operand.
   always_comb begin
      logic carry;
      sum   = '0;
      carry = add_sub;
      for (int i = 0; i < int'(DW) + 2; i++) begin
         sum[i] = add_a[i] ^ add_b[i] ^ carry;
         carry  = (add_a[i] & add_b[i]) | (carry & (add_a[i] ^ add_b[i]));
      end
   end

   // Arithmetic shift by one then truncation keeps bits DW..1.
   assign unused_sum_bits = sum[DW+1] ^ sum[0];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_en       = 1'b0;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_err_d   = out_err_q;

      unique case (state_q)
         StLoad: begin
            in_ready_d = 1'b1;
            if (bus.in_valid && in_ready_q) begin
               wr_en = 1'b1;
               cnt_d = 3'(cnt_q + 3'd1);
               if (cnt_q == 3'd7) begin
                  state_d     = StDrain;
                  in_ready_d  = 1'b0;
                  cnt_d       = 3'd0;
                  out_valid_d = 1'b1;
                  out_data_d  = sum[DW:1];
                  out_last_d  = 1'b0;
                  out_err_d   = pair_err;
               end
            end
         end
         StDrain: begin
            if (out_valid_q && bus.out_ready) begin
               if (cnt_q == 3'd7) begin
                  state_d     = StLoad;
                  cnt_d       = 3'd0;
                  in_ready_d  = 1'b1;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
               end else begin
                  cnt_d      = 3'(cnt_q + 3'd1);
                  out_data_d = sum[DW:1];
                  out_last_d = (rd_idx == 3'd7);
                  out_err_d  = pair_err;
               end
            end
         end
         default: state_d = StLoad;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StLoad;
         cnt_q       <= 3'd0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_err_q   <= out_err_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            rf_q[i] <= '0;
         end
      end else if (wr_en) begin
         rf_q[cnt_q] <= bus.in_data;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_butterfly_recombine.sv
// Directed and randomized checks of butterfly_recombine against an arithmetic model.
module tb_butterfly_recombine;
   localparam int unsigned DW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   butterfly_recombine_if #(.DW(DW)) bus ();

   butterfly_recombine #(.DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          total = 0;
   int          bad   = 0;
   int          ein [4];
   int          oin [4];
   int          xv  [8];
   logic [15:0] exp_data [8];
   logic        exp_err  [8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Expected samples come straight from the original x values.
   task automatic pairs_from_x();
      int t;
      for (int i = 0; i < 4; i++) begin
         ein[i] = xv[i] + xv[7-i];
         oin[i] = xv[i] - xv[7-i];
      end
      for (int k = 0; k < 8; k++) begin
         t           = xv[k];
         exp_data[k] = t[15:0];
         exp_err[k]  = 1'b0;
      end
   endtask

   task automatic random_x();
      logic signed [15:0] r;
      for (int k = 0; k < 8; k++) begin
         r     = 16'($urandom);
         xv[k] = int'(r);
      end
      pairs_from_x();
   endtask

   // Arbitrary e/o pairs: floor((e +/- o) / 2), wrapped to 16 bits.
   task automatic random_pairs();
      logic signed [16:0] r;
      int p, s, v;
      for (int i = 0; i < 4; i++) begin
         r = 17'($urandom); ein[i] = int'(r);
         r = 17'($urandom); oin[i] = int'(r);
      end
      for (int k = 0; k < 8; k++) begin
         p           = (k < 4) ? k : 7 - k;
         s           = (k < 4) ? ein[p] + oin[p] : ein[p] - oin[p];
         v           = s >>> 1;
         exp_data[k] = v[15:0];
         exp_err[k]  = ((ein[p] ^ oin[p]) & 1) != 0;
      end
   endtask

   task automatic feed(input bit gaps, input int n);
      int w, b;
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         w            = (i < 4) ? ein[i] : oin[i-4];
         bus.in_valid = 1'b1;
         bus.in_data  = 17'(w);
         b            = 0;
         while (!bus.in_ready && b < 40) begin
            @(negedge clk);
            b++;
         end
         chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input int n, input int stall_k);
      int b;
      for (int k = 0; k < n; k++) begin
         bus.in_valid = (k < 6);
         bus.in_data  = 17'($urandom);
         if (k == stall_k) begin
            bus.out_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               chk("stall_valid", 32'(bus.out_valid), 32'd1);
               chk("stall_data", 32'(bus.out_data), 32'(exp_data[k]));
            end
         end
         bus.out_ready = 1'b1;
         b = 0;
         while (!bus.out_valid && b < 40) begin
            @(negedge clk);
            b++;
         end
         chk("out_valid", 32'(bus.out_valid), 32'd1);
         chk($sformatf("x%0d_data", k), 32'(bus.out_data), 32'(exp_data[k]));
         chk($sformatf("x%0d_last", k), 32'(bus.out_last), 32'(k == 7));
         chk($sformatf("x%0d_err", k), 32'(bus.out_err), 32'(exp_err[k]));
         chk("drain_in_ready", 32'(bus.in_ready), 32'd0);
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      if (n == 8) begin
         chk("post_block_valid", 32'(bus.out_valid), 32'd0);
         chk("post_block_ready", 32'(bus.in_ready), 32'd1);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
      chk({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
      chk({tag, "_out_err"}, 32'(bus.out_err), 32'd0);
   endtask

   task automatic full_block(input bit gaps, input int stall_k);
      feed(gaps, 8);
      chk("latency_valid", 32'(bus.out_valid), 32'd1);
      drain(8, stall_k);
   endtask

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 32'(bus.in_ready), 32'd1);

      // Basic block from known samples
      xv[0] = 100; xv[1] = -200; xv[2] = 300; xv[3] = -400;
      xv[4] = 500; xv[5] = -600; xv[6] = 700; xv[7] = -800;
      pairs_from_x();
      full_block(1'b0, -1);

      // Extremes: no wrap in the widened intermediate
      for (int i = 0; i < 4; i++) begin ein[i] = 0; oin[i] = 0; end
      ein[0] = -1; oin[0] = 65535;
      for (int k = 0; k < 8; k++) begin exp_data[k] = 16'h0; exp_err[k] = 1'b0; end
      exp_data[0] = 16'h7fff;
      exp_data[7] = 16'h8000;
      full_block(1'b0, -1);

      // Parity mismatch on pair 0
      for (int i = 0; i < 4; i++) begin ein[i] = 0; oin[i] = 0; end
      ein[0] = 3;
      for (int k = 0; k < 8; k++) begin exp_data[k] = 16'h0; exp_err[k] = 1'b0; end
      exp_data[0] = 16'd1; exp_err[0] = 1'b1;
      exp_data[7] = 16'd1; exp_err[7] = 1'b1;
      full_block(1'b0, -1);

      // Backpressure on x2 with input gaps
      random_x();
      full_block(1'b1, 2);

      for (int r = 0; r < 6; r++) begin
         random_pairs();
         full_block(1'b1, int'($urandom_range(0, 8)));
      end

      // Reset mid-load, then a fresh block
      random_x();
      feed(1'b0, 5);
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_load");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_load_ready", 32'(bus.in_ready), 32'd1);
      random_x();
      full_block(1'b0, -1);

      // Reset mid-drain at x3
      random_x();
      feed(1'b0, 8);
      drain(3, -1);
      chk("x3_before_rst", 32'(bus.out_data), 32'(exp_data[3]));
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_drain");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_drain_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_drain_no_residual", 32'(bus.out_valid), 32'd0);
      random_pairs();
      full_block(1'b1, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
